// File: rtl/irq_controller.sv
// Interrupt controller: rising-edge capture into a pending register, masked lowest-index
// arbitration, and an irq/ack/eoi handshake to the core with exception PC capture.
module irq_controller #(
    parameter  int NUM_SRC = 8,
    localparam int ID_W    = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic               mask_wr_en,
    input  logic [NUM_SRC-1:0] mask_wr_data,
    input  logic [31:0]        pc_in,
    input  logic               irq_ack,
    input  logic               irq_eoi,
    output logic               irq,
    output logic [ID_W-1:0]    irq_id,
    output logic [31:0]        epc,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [NUM_SRC-1:0] src_d;
    logic [NUM_SRC-1:0] edge_vec;
    logic [NUM_SRC-1:0] req_vec;
    logic [NUM_SRC-1:0] clear_vec;
    logic [ID_W-1:0]    winner;
    logic               load_id;
    logic               ack_take;

    assign edge_vec  = src_in & ~src_d;
    assign req_vec   = pending & mask;
    assign clear_vec = ack_take ? (NUM_SRC'(1) << irq_id) : '0;

    // Walking from the top down lets the lowest set index overwrite the others.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_vec[i]) winner = ID_W'(i);
        end
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        load_id    = 1'b0;
        ack_take   = 1'b0;
        case (state)
            IDLE: begin
                if (|req_vec) begin
                    state_next = REQ;
                    load_id    = 1'b1;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_next = SERVICE;
                    ack_take   = 1'b1;
                end
            end
            SERVICE: begin
                if (irq_eoi) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // src_d follows src_in even in reset, so a line already high at release is not an edge.
    always_ff @(posedge clk) begin
        src_d <= src_in;
        if (reset) begin
            pending <= '0;
            mask    <= '0;
            irq_id  <= '0;
            epc     <= '0;
        end else begin
            pending <= (pending & ~clear_vec) | edge_vec;
            if (mask_wr_en) mask   <= mask_wr_data;
            if (load_id)    irq_id <= winner;
            if (ack_take)   epc    <= pc_in;
        end
    end

    assign irq  = (state == REQ);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed sequences, a stimulus table and a randomized
// run compared each cycle against a flag-based reference model of the interrupt rules.
module tb_irq_controller;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] src_in;
    logic         mask_wr_en;
    logic [N-1:0] mask_wr_data;
    logic [31:0]  pc_in;
    logic         irq_ack;
    logic         irq_eoi;
    logic         irq;
    logic [2:0]   irq_id;
    logic [31:0]  epc;
    logic [N-1:0] pending;
    logic [N-1:0] mask;
    logic         busy;

    int n_cmp  = 0;
    int n_fail = 0;

    irq_controller #(.NUM_SRC(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .src_in       (src_in),
        .mask_wr_en   (mask_wr_en),
        .mask_wr_data (mask_wr_data),
        .pc_in        (pc_in),
        .irq_ack      (irq_ack),
        .irq_eoi      (irq_eoi),
        .irq          (irq),
        .irq_id       (irq_id),
        .epc          (epc),
        .pending      (pending),
        .mask         (mask),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a request is outstanding, or a handler is running, or neither.
    logic [N-1:0] m_prev, m_pend, m_mask;
    bit           m_req, m_svc;
    logic [2:0]   m_id;
    logic [31:0]  m_epc;

    function automatic logic [2:0] lowest(input logic [N-1:0] v);
        logic [N-1:0] iso;
        iso = v & (~v + 1'b1);
        return 3'($clog2(iso));
    endfunction

    task automatic model_step();
        logic [N-1:0] rises;
        logic [N-1:0] taken;
        if (reset) begin
            m_prev = src_in; m_pend = '0; m_mask = '0;
            m_req = 0; m_svc = 0; m_id = '0; m_epc = '0;
            return;
        end
        rises  = src_in & ~m_prev;
        m_prev = src_in;
        taken  = '0;
        if (m_req) begin
            if (irq_ack) begin
                taken = N'(1) << m_id;
                m_epc = pc_in;
                m_req = 0;
                m_svc = 1;
            end
        end else if (m_svc) begin
            if (irq_eoi) m_svc = 0;
        end else if ((m_pend & m_mask) != 0) begin
            m_req = 1;
            m_id  = lowest(m_pend & m_mask);
        end
        m_pend = (m_pend & ~taken) | rises;
        if (mask_wr_en) m_mask = mask_wr_data;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [N-1:0] s, input logic we,
                         input logic [N-1:0] wd, input logic [31:0] pc,
                         input logic ack, input logic eoi);
        reset = r; src_in = s; mask_wr_en = we; mask_wr_data = wd;
        pc_in = pc; irq_ack = ack; irq_eoi = eoi;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_irq",     32'(irq),     32'(m_req));
        check("model_irq_id",  32'(irq_id),  32'(m_id));
        check("model_epc",     epc,          m_epc);
        check("model_pending", 32'(pending), 32'(m_pend));
        check("model_mask",    32'(mask),    32'(m_mask));
        check("model_busy",    32'(busy),    32'(m_req | m_svc));
    endtask

    typedef struct {
        logic [N-1:0] src;
        logic         we;
        logic [N-1:0] wd;
        logic [31:0]  pc;
        logic         ack;
        logic         eoi;
        logic         e_irq;
        logic [2:0]   e_id;
        logic [N-1:0] e_pend;
        logic [31:0]  e_epc;
        logic         e_busy;
    } vec_t;

    vec_t vec[9];

    initial begin
        drive(1'b1, 8'h01, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);

        // 1: line high through reset release is not an edge
        tick();
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_pending", 32'(pending), 32'h0);
        drive(1'b0, 8'h01, 1'b1, 8'hFF, 32'h0, 1'b0, 1'b0);
        tick();
        mask_wr_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("held_src_no_irq", 32'(irq), 32'h0);
        src_in = 8'h00; tick();
        src_in = 8'h01; tick();
        check("rise_pending", 32'(pending), 32'h01);
        check("rise_irq_1cyc", 32'(irq), 32'h0);
        tick();
        check("rise_irq_2cyc", 32'(irq), 32'h1);
        check("rise_irq_id", 32'(irq_id), 32'h0);
        irq_ack = 1'b1; pc_in = 32'h40; tick();
        irq_ack = 1'b0; irq_eoi = 1'b1; tick();
        irq_eoi = 1'b0;

        // 2: masked source latches but waits for the mask
        drive(1'b0, 8'h00, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0); tick();
        drive(1'b0, 8'h08, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0); tick();
        src_in = 8'h00; tick(); tick();
        check("masked_pending", 32'(pending), 32'h08);
        check("masked_no_irq", 32'(irq), 32'h0);
        mask_wr_en = 1'b1; mask_wr_data = 8'h08; tick();
        mask_wr_en = 1'b0; tick();
        check("unmask_irq", 32'(irq), 32'h1);
        check("unmask_id", 32'(irq_id), 32'h3);
        irq_ack = 1'b1; tick();
        irq_ack = 1'b0; irq_eoi = 1'b1; tick();
        irq_eoi = 1'b0;

        // 3: table-driven priority, ack and eoi sequence
        vec[0] = '{8'h00, 1'b1, 8'hFF, 32'h0,   1'b0, 1'b0, 1'b0, 3'd3, 8'h00, 32'h0,   1'b0};
        vec[1] = '{8'h24, 1'b0, 8'h00, 32'h0,   1'b0, 1'b0, 1'b0, 3'd3, 8'h24, 32'h0,   1'b0};
        vec[2] = '{8'h00, 1'b0, 8'h00, 32'h0,   1'b0, 1'b0, 1'b1, 3'd2, 8'h24, 32'h0,   1'b1};
        vec[3] = '{8'h00, 1'b0, 8'h00, 32'h120, 1'b1, 1'b0, 1'b0, 3'd2, 8'h20, 32'h120, 1'b1};
        vec[4] = '{8'h00, 1'b0, 8'h00, 32'h0,   1'b0, 1'b0, 1'b0, 3'd2, 8'h20, 32'h120, 1'b1};
        vec[5] = '{8'h00, 1'b0, 8'h00, 32'h0,   1'b0, 1'b1, 1'b0, 3'd2, 8'h20, 32'h120, 1'b0};
        vec[6] = '{8'h00, 1'b0, 8'h00, 32'h0,   1'b0, 1'b0, 1'b1, 3'd5, 8'h20, 32'h120, 1'b1};
        vec[7] = '{8'h00, 1'b0, 8'h00, 32'h200, 1'b1, 1'b0, 1'b0, 3'd5, 8'h00, 32'h200, 1'b1};
        vec[8] = '{8'h00, 1'b0, 8'h00, 32'h0,   1'b0, 1'b1, 1'b0, 3'd5, 8'h00, 32'h200, 1'b0};
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, vec[i].src, vec[i].we, vec[i].wd, vec[i].pc, vec[i].ack, vec[i].eoi);
            tick();
            check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vec[i].e_irq));
            check($sformatf("vec%0d_id", i), 32'(irq_id), 32'(vec[i].e_id));
            check($sformatf("vec%0d_pending", i), 32'(pending), 32'(vec[i].e_pend));
            check($sformatf("vec%0d_epc", i), epc, vec[i].e_epc);
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vec[i].e_busy));
        end
        irq_eoi = 1'b0;

        // 4: edges during SERVICE wait for eoi
        src_in = 8'h10; tick();
        tick();
        irq_ack = 1'b1; tick();
        irq_ack = 1'b0; src_in = 8'h12; tick();
        src_in = 8'h00; tick(); tick();
        check("svc_no_irq", 32'(irq), 32'h0);
        check("svc_pending", 32'(pending), 32'h02);
        irq_eoi = 1'b1; tick();
        irq_eoi = 1'b0;
        check("eoi_idle_irq", 32'(irq), 32'h0);
        tick();
        check("after_eoi_irq", 32'(irq), 32'h1);
        check("after_eoi_id", 32'(irq_id), 32'h1);
        irq_ack = 1'b1; tick();
        irq_ack = 1'b0; irq_eoi = 1'b1; tick();
        irq_eoi = 1'b0;

        // 5: set wins over clear on the acknowledged source
        src_in = 8'h10; tick();
        src_in = 8'h00; tick();
        check("req4_id", 32'(irq_id), 32'h4);
        src_in = 8'h10; irq_ack = 1'b1; tick();
        irq_ack = 1'b0;
        check("set_wins_pending", 32'(pending), 32'h10);
        src_in = 8'h00; irq_eoi = 1'b1; tick();
        irq_eoi = 1'b0; tick();
        check("rereq4_irq", 32'(irq), 32'h1);
        irq_ack = 1'b1; tick();
        irq_ack = 1'b0; irq_eoi = 1'b1; tick();
        irq_eoi = 1'b0;

        // 6: reset in SERVICE, then stray handshake pulses
        src_in = 8'h0C; tick();
        src_in = 8'h00; tick();
        irq_ack = 1'b1; tick();
        irq_ack = 1'b0; src_in = 8'h04; tick();
        check("pre_reset_pending", 32'(pending), 32'h0C);
        check("pre_reset_busy", 32'(busy), 32'h1);
        reset = 1'b1; tick();
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_id", 32'(irq_id), 32'h0);
        check("rst_epc", epc, 32'h0);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_mask", 32'(mask), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1); tick();
        check("stray_eoi_busy", 32'(busy), 32'h0);
        drive(1'b0, 8'h01, 1'b1, 8'hFF, 32'h0, 1'b0, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0); tick();
        irq_ack = 1'b1; pc_in = 32'h300; tick();
        src_in = 8'h80; pc_in = 32'h400; tick();
        irq_ack = 1'b0;
        check("stray_ack_epc", epc, 32'h300);
        check("stray_ack_pending", 32'(pending), 32'h80);
        check("stray_ack_busy", 32'(busy), 32'h1);

        // Randomized run against the reference model
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 99) == 0);
            src_in       = N'($urandom);
            mask_wr_en   = ($urandom_range(0, 7) == 0);
            mask_wr_data = N'($urandom);
            pc_in        = $urandom;
            irq_ack      = ($urandom_range(0, 3) == 0);
            irq_eoi      = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
